vu_meter_engine: RTL and testbench

Multi-channel VU meter engine. Each channel rectifies a signed audio sample stream, measures its level over a fixed window as an average or a peak, and applies fall-back ballistics. It then drives a PWM output to an analog meter coil. It sits between the audio data path (per-channel sample strobes) and the front-panel meter pins. It adds channel count, sample width, peak mode, ballistics and a level readback port.

---
 rtl/vu_meter_engine.sv | 202 ++++++++++++++++++++
 tb/tb_vu_meter_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vu_meter_engine.sv
// Multi-channel VU meter engine: rectify, window average/peak, fall-back
// ballistics and a PWM meter-coil drive per channel, plus a level readback.
module vu_meter_engine #(
  parameter int NUM_CH       = 2,
  parameter int SAMPLE_W     = 8,
  parameter int AVG_LOG2     = 4,
  parameter int PWM_BITS     = 7,
  parameter int PWM_PRESCALE = 64,
  parameter int DECAY_STEP   = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         audio_enable,
  input  logic [NUM_CH-1:0]            data_en,
  input  logic [NUM_CH*SAMPLE_W-1:0]   audio_signal,
  input  logic                         mode,
  input  logic                         test_en,
  input  logic [PWM_BITS-1:0]          test_level,
  output logic [NUM_CH-1:0]            vu_out,
  output logic [NUM_CH*PWM_BITS-1:0]   level,
  output logic [NUM_CH-1:0]            level_valid
);

  localparam int MAG_W = SAMPLE_W - 1;
  localparam int ACC_W = MAG_W + AVG_LOG2;
  localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

  // Measurement state
  logic [AVG_LOG2-1:0] cnt_q  [NUM_CH];
  logic [AVG_LOG2-1:0] cnt_d  [NUM_CH];
  logic [ACC_W-1:0]    acc_q  [NUM_CH];
  logic [ACC_W-1:0]    acc_d  [NUM_CH];
  logic [MAG_W-1:0]    max_q  [NUM_CH];
  logic [MAG_W-1:0]    max_d  [NUM_CH];
  logic [MAG_W-1:0]    win_q  [NUM_CH];
  logic [MAG_W-1:0]    win_d  [NUM_CH];
  logic [PWM_BITS-1:0] new_q  [NUM_CH];
  logic [PWM_BITS-1:0] new_d  [NUM_CH];
  logic [PWM_BITS-1:0] disp_q [NUM_CH];
  logic [PWM_BITS-1:0] disp_d [NUM_CH];
  logic [NUM_CH-1:0]   win_vld_q, win_vld_d;
  logic [NUM_CH-1:0]   new_vld_q, new_vld_d;
  logic [NUM_CH-1:0]   valid_q, valid_d;
  logic                mode_q, mode_d;

  // PWM state
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PWM_BITS-1:0] frame_q, frame_d;
  logic [PWM_BITS-1:0] duty_q [NUM_CH];
  logic [PWM_BITS-1:0] duty_d [NUM_CH];
  logic [NUM_CH-1:0]   vu_q, vu_d;

  // Combinational helpers
  logic [MAG_W-1:0]    mag  [NUM_CH];
  logic [ACC_W-1:0]    sum  [NUM_CH];
  logic [MAG_W-1:0]    peak [NUM_CH];
  logic                mode_chg;
  logic                tick;
  logic                frame_wrap;

  // |x| on SAMPLE_W-1 bits; the most negative code saturates to full scale
  function automatic logic [MAG_W-1:0] rectify(input logic [SAMPLE_W-1:0] x);
    logic [SAMPLE_W-1:0] neg;
    neg = -x;
    if (!x[SAMPLE_W-1]) begin
      return x[MAG_W-1:0];
    end else if (x[MAG_W-1:0] == '0) begin
      return {MAG_W{1'b1}};
    end else begin
      return neg[MAG_W-1:0];
    end
  endfunction

  // Instant attack, bounded fall of DECAY_STEP per window, floor at zero
  function automatic logic [PWM_BITS-1:0] ballistics(input logic [PWM_BITS-1:0] nv,
                                                     input logic [PWM_BITS-1:0] dv);
    logic [PWM_BITS-1:0] fall;
    fall = (dv > PWM_BITS'(DECAY_STEP)) ? dv - PWM_BITS'(DECAY_STEP) : '0;
    if (nv >= dv) begin
      return nv;
    end else begin
      return (nv > fall) ? nv : fall;
    end
  endfunction

  // Per-channel rectified magnitude, running sum and running max
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      mag[c]  = rectify(audio_signal[c*SAMPLE_W +: SAMPLE_W]);
      sum[c]  = acc_q[c] + ACC_W'(mag[c]);
      peak[c] = (mag[c] > max_q[c]) ? mag[c] : max_q[c];
    end
  end

  // Window accumulation, completion pipeline and ballistics
  always_comb begin
    mode_d    = mode;
    mode_chg  = (mode != mode_q);
    win_vld_d = '0;
    new_vld_d = win_vld_q;
    valid_d   = new_vld_q;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c]  = cnt_q[c];
      acc_d[c]  = acc_q[c];
      max_d[c]  = max_q[c];
      win_d[c]  = win_q[c];
      new_d[c]  = win_q[c][MAG_W-1 -: PWM_BITS];
      disp_d[c] = new_vld_q[c] ? ballistics(new_q[c], disp_q[c]) : disp_q[c];

      if (!audio_enable) begin
        cnt_d[c]     = '0;
        acc_d[c]     = '0;
        max_d[c]     = '0;
        disp_d[c]    = '0;
        new_vld_d[c] = 1'b0;
        valid_d[c]   = 1'b0;
      end else if (mode_chg) begin
        cnt_d[c] = '0;
        acc_d[c] = '0;
        max_d[c] = '0;
      end else if (data_en[c]) begin
        if (cnt_q[c] == {AVG_LOG2{1'b1}}) begin
          win_d[c]     = mode ? peak[c] : sum[c][ACC_W-1:AVG_LOG2];
          win_vld_d[c] = 1'b1;
          cnt_d[c]     = '0;
          acc_d[c]     = '0;
          max_d[c]     = '0;
        end else begin
          cnt_d[c] = cnt_q[c] + AVG_LOG2'(1);
          acc_d[c] = sum[c];
          max_d[c] = peak[c];
        end
      end
    end
  end

  // Shared prescaler/frame counter, glitch-free duty latch and PWM compare
  always_comb begin
    tick       = (pre_q == PRE_W'(PWM_PRESCALE - 1));
    pre_d      = tick ? '0 : pre_q + PRE_W'(1);
    frame_wrap = tick && (frame_q == {PWM_BITS{1'b1}});
    frame_d    = tick ? frame_q + PWM_BITS'(1) : frame_q;
    for (int c = 0; c < NUM_CH; c++) begin
      duty_d[c] = duty_q[c];
      if (frame_wrap) begin
        duty_d[c] = test_en ? test_level : disp_q[c];
      end
      vu_d[c] = (frame_q < duty_q[c]);
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_vld_q <= '0;
      new_vld_q <= '0;
      valid_q   <= '0;
      mode_q    <= 1'b0;
      pre_q     <= '0;
      frame_q   <= '0;
      vu_q      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]  <= '0;
        acc_q[c]  <= '0;
        max_q[c]  <= '0;
        win_q[c]  <= '0;
        new_q[c]  <= '0;
        disp_q[c] <= '0;
        duty_q[c] <= '0;
      end
    end else begin
      win_vld_q <= win_vld_d;
      new_vld_q <= new_vld_d;
      valid_q   <= valid_d;
      mode_q    <= mode_d;
      pre_q     <= pre_d;
      frame_q   <= frame_d;
      vu_q      <= vu_d;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]  <= cnt_d[c];
        acc_q[c]  <= acc_d[c];
        max_q[c]  <= max_d[c];
        win_q[c]  <= win_d[c];
        new_q[c]  <= new_d[c];
        disp_q[c] <= disp_d[c];
        duty_q[c] <= duty_d[c];
      end
    end
  end

  // Pack displayed levels onto the readback port
  always_comb begin
    level = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      level[c*PWM_BITS +: PWM_BITS] = disp_q[c];
    end
  end

  assign vu_out      = vu_q;
  assign level_valid = valid_q;

endmodule

// File: tb/tb_vu_meter_engine.sv
// Directed bench for vu_meter_engine with a level_valid scoreboard and
// PWM high-time measurement over whole frames.
module tb_vu_meter_engine;

  localparam int NUM_CH   = 2;
  localparam int SAMPLE_W = 8;
  localparam int PWM_BITS = 7;
  localparam int FRAME    = 8192;

  logic                       clk = 1'b0;
  logic                       reset_n;
  logic                       audio_enable;
  logic [NUM_CH-1:0]          data_en;
  logic [NUM_CH*SAMPLE_W-1:0] audio_signal;
  logic                       mode;
  logic                       test_en;
  logic [PWM_BITS-1:0]        test_level;
  logic [NUM_CH-1:0]          vu_out;
  logic [NUM_CH*PWM_BITS-1:0] level;
  logic [NUM_CH-1:0]          level_valid;

  typedef struct {
    int ch;
    int lvl;
    int cyc;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   mCnt[NUM_CH];
  int   mAcc[NUM_CH];
  int   mMax[NUM_CH];
  int   mDisp[NUM_CH];

  vu_meter_engine dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .audio_enable (audio_enable),
    .data_en      (data_en),
    .audio_signal (audio_signal),
    .mode         (mode),
    .test_en      (test_en),
    .test_level   (test_level),
    .vu_out       (vu_out),
    .level        (level),
    .level_valid  (level_valid)
  );

  // 10 ns clock and a free-running edge counter used to time level_valid
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int magOf(input int x);
    if (x == -128) return 127;
    return (x < 0) ? -x : x;
  endfunction

  task automatic clearWindows();
    for (int c = 0; c < NUM_CH; c++) begin
      mCnt[c] = 0;
      mAcc[c] = 0;
      mMax[c] = 0;
    end
  endtask

  task automatic clearModel();
    clearWindows();
    for (int c = 0; c < NUM_CH; c++) mDisp[c] = 0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one clk-wide strobe and advance the reference model; a completing
  // window schedules its expected level for two edges after the sampling edge
  task automatic applyStimulus(input logic [NUM_CH-1:0] en, input int s0, input int s1);
    int s[NUM_CH];
    int m, res;
    s[0] = s0;
    s[1] = s1;
    data_en = en;
    audio_signal = {8'(s1), 8'(s0)};
    if (!audio_enable) begin
      clearModel();
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (en[c]) begin
          m = magOf(s[c]);
          mAcc[c] += m;
          if (m > mMax[c]) mMax[c] = m;
          mCnt[c]++;
          if (mCnt[c] == 16) begin
            res = mode ? mMax[c] : (mAcc[c] / 16);
            if (res < mDisp[c]) begin
              mDisp[c] = mDisp[c] - 8;
              if (mDisp[c] < 0) mDisp[c] = 0;
              if (res > mDisp[c]) mDisp[c] = res;
            end else begin
              mDisp[c] = res;
            end
            expQ.push_back('{c, mDisp[c], cyc + 3});
            mCnt[c] = 0;
            mAcc[c] = 0;
            mMax[c] = 0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    data_en = '0;
  endtask

  task automatic setMode(input logic v);
    mode = v;
    clearWindows();
    waitCycles(1);
  endtask

  task automatic countHigh(output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    repeat (FRAME) begin
      @(negedge clk);
      h0 += int'(vu_out[0]);
      h1 += int'(vu_out[1]);
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each level_valid pattern must match the entries due this cycle
  always @(negedge clk) begin
    logic [NUM_CH-1:0] expMask;
    if (reset_n) begin
      expMask = '0;
      while (expQ.size() > 0 && expQ[0].cyc == cyc) begin
        exp_t e;
        e = expQ.pop_front();
        expMask[e.ch] = 1'b1;
        checkOutput($sformatf("sb_level_ch%0d", e.ch), 32'(level[e.ch*PWM_BITS +: PWM_BITS]), e.lvl);
      end
      if (level_valid !== '0 || expMask != '0) begin
        checkOutput("sb_valid_mask", 32'(level_valid), 32'(expMask));
      end
    end
  end

  initial begin
    int h0, h1, k;
    reset_n      = 1'b0;
    audio_enable = 1'b0;
    data_en      = '0;
    audio_signal = '0;
    mode         = 1'b0;
    test_en      = 1'b0;
    test_level   = '0;
    clearModel();

    #12;
    checkOutput("reset_vu_out", 32'(vu_out), 0);
    checkOutput("reset_level", 32'(level), 0);
    checkOutput("reset_valid", 32'(level_valid), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    waitCycles(2);
    audio_enable = 1'b1;
    waitCycles(1);

    $display("[TB] average mode, ch0 at +64");
    repeat (16) applyStimulus(2'b01, 64, 0);
    waitCycles(4);
    checkOutput("avg_level_ch0", 32'(level[6:0]), 64);
    checkOutput("avg_level_ch1_untouched", 32'(level[13:7]), 0);

    $display("[TB] saturation, ch1 at -128");
    repeat (16) applyStimulus(2'b10, 0, -128);
    waitCycles(4);
    checkOutput("sat_level_ch1", 32'(level[13:7]), 127);
    waitCycles(FRAME + 8);
    countHigh(h0, h1);
    checkOutput("pwm_high_ch0_duty64", h0, 4096);
    checkOutput("pwm_high_ch1_duty127", h1, 8128);

    $display("[TB] disable mid-window");
    repeat (10) applyStimulus(2'b01, 50, 0);
    audio_enable = 1'b0;
    clearModel();
    waitCycles(1);
    checkOutput("disable_level_zero", 32'(level), 0);
    audio_enable = 1'b1;
    repeat (16) applyStimulus(2'b01, 32, 0);
    waitCycles(4);
    checkOutput("after_disable_level_ch0", 32'(level[6:0]), 32);

    $display("[TB] disable coinciding with completing strobe");
    repeat (15) applyStimulus(2'b01, 32, 0);
    audio_enable = 1'b0;
    applyStimulus(2'b01, 32, 0);
    audio_enable = 1'b1;
    waitCycles(4);
    checkOutput("disable_wins_level_ch0", 32'(level[6:0]), 0);

    $display("[TB] peak mode with decay");
    setMode(1'b1);
    repeat (15) applyStimulus(2'b11, 0, 0);
    applyStimulus(2'b11, 100, 0);
    waitCycles(3);
    checkOutput("peak_level_ch0", 32'(level[6:0]), 100);
    for (int w = 1; w <= 3; w++) begin
      repeat (16) applyStimulus(2'b11, 0, 0);
      waitCycles(3);
      checkOutput($sformatf("decay_w%0d_ch0", w), 32'(level[6:0]), 100 - 8 * w);
    end
    repeat (8) applyStimulus(2'b11, 0, 0);
    applyStimulus(2'b11, 90, -90);
    repeat (7) applyStimulus(2'b11, -20, 5);
    waitCycles(3);
    checkOutput("peak90_ch0", 32'(level[6:0]), 90);
    checkOutput("peak90_ch1", 32'(level[13:7]), 90);
    repeat (15) applyStimulus(2'b01, 10, 0);
    applyStimulus(2'b01, -100, 0);
    waitCycles(3);
    checkOutput("peak100_ch0", 32'(level[6:0]), 100);

    $display("[TB] test mode override");
    test_level = 7'd32;
    test_en    = 1'b1;
    waitCycles(FRAME + 8);
    countHigh(h0, h1);
    checkOutput("test_high_ch0", h0, 2048);
    checkOutput("test_high_ch1", h1, 2048);
    checkOutput("test_level_unchanged_ch0", 32'(level[6:0]), 100);

    $display("[TB] asynchronous reset mid-frame");
    k = 0;
    while (vu_out[0] !== 1'b1 && k < 10000) begin
      @(negedge clk);
      k++;
    end
    checkOutput("vu_high_before_reset", 32'(vu_out[0]), 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_vu_out", 32'(vu_out), 0);
    checkOutput("async_reset_level", 32'(level), 0);
    checkOutput("async_reset_valid", 32'(level_valid), 0);
    expQ.delete();
    clearModel();
    test_en = 1'b0;
    mode    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    countHigh(h0, h1);
    checkOutput("post_reset_frame_ch0", h0, 0);
    checkOutput("post_reset_frame_ch1", h1, 0);

    waitCycles(4);
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
